// File: rtl/skein_instr_pkg.sv
// Shared definitions for the 21-bit instruction word driven by the instruction
// sub-sequencers: field layout, fixed opcodes, sequencer state and the packer.
package skein_instr_pkg;

  localparam int INSTR_W      = 21;
  localparam int INSTR_ADDR_W = 8;

  // Bit positions, LSB first: global_command, alu_opcode, output_enable,
  // output_select, input_select, address, ram_write, save_core_sel.
  localparam int GCMD_LSB   = 0;
  localparam int ALU_LSB    = 3;
  localparam int OE_BIT     = 7;
  localparam int OSEL_BIT   = 8;
  localparam int INSEL_LSB  = 9;
  localparam int ADDR_LSB   = 11;
  localparam int RAM_WR_BIT = 19;
  localparam int SAVE_BIT   = 20;

  localparam logic [3:0] ALU_PASS  = 4'hC;
  localparam logic [2:0] GCMD_NONE = 3'd0;

  typedef enum logic [1:0] {IDLE, ADDR, TAIL} seq_state_e;

  typedef struct packed {
    logic                    save_core_sel;
    logic                    ram_write;
    logic [INSTR_ADDR_W-1:0] address;
    logic [1:0]              input_select;
    logic                    output_select;
    logic                    output_enable;
    logic [3:0]              alu_opcode;
    logic [2:0]              global_command;
  } instr_t;

  function automatic logic [INSTR_W-1:0] pack_instr(instr_t f);
    logic [INSTR_W-1:0] w;
    w                          = '0;
    w[SAVE_BIT]                = f.save_core_sel;
    w[RAM_WR_BIT]              = f.ram_write;
    w[ADDR_LSB +: INSTR_ADDR_W] = f.address;
    w[INSEL_LSB +: 2]          = f.input_select;
    w[OSEL_BIT]                = f.output_select;
    w[OE_BIT]                  = f.output_enable;
    w[ALU_LSB +: 4]            = f.alu_opcode;
    w[GCMD_LSB +: 3]           = f.global_command;
    return w;
  endfunction

endpackage

// File: rtl/burst_access_sequencer_if.sv
// Request/instruction bus of the burst sequencer; the master issues bursts,
// the slave (sequencer) drives the shared instruction bus.
interface burst_access_sequencer_if #(
  parameter int BASE_W = 6
);
  logic                                start_i;
  logic                                write_i;
  logic [BASE_W-1:0]                   base_addr_i;
  logic [1:0]                          input_select_i;
  logic                                abort_i;
  logic                                busy_o;
  logic [skein_instr_pkg::INSTR_W-1:0] instruction_o;
  logic                                instr_valid_o;
  logic                                done_o;

  modport master (
    output start_i, write_i, base_addr_i, input_select_i, abort_i,
    input  busy_o, instruction_o, instr_valid_o, done_o
  );

  modport slave (
    input  start_i, write_i, base_addr_i, input_select_i, abort_i,
    output busy_o, instruction_o, instr_valid_o, done_o
  );
endinterface

// File: rtl/instr_word_pack.sv
// Combinational field packer; forces an all-zero word when not valid so the
// result can be OR-ed onto the shared instruction bus.
module instr_word_pack
  import skein_instr_pkg::*;
(
  input  instr_t               fields,
  input  logic                 valid,
  output logic [INSTR_W-1:0]   word
);

  assign word = valid ? pack_instr(fields) : '0;

endmodule

// File: rtl/burst_access_sequencer.sv
// Expands one start request into BEATS consecutive RAM access words, plus a
// READ_LAT output-enable tail on reads. All outputs come from registers.
module burst_access_sequencer
  import skein_instr_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int BEATS    = 4,
  parameter int BEAT_W   = $clog2(BEATS),
  parameter int BASE_W   = ADDR_W - BEAT_W,
  parameter int READ_LAT = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  burst_access_sequencer_if.slave    bus
);

  if ((BEATS < 2) || (BEATS > 64) || ((BEATS & (BEATS - 1)) != 0)) begin : g_bad_beats
    $error("BEATS must be a power of two in 2..64");
  end
  if ((READ_LAT < 0) || (READ_LAT > 3)) begin : g_bad_lat
    $error("READ_LAT must be in 0..3");
  end
  if ((ADDR_W != INSTR_ADDR_W) || (BEAT_W != $clog2(BEATS))) begin : g_bad_width
    $error("ADDR_W is fixed by the instruction format and BEAT_W is derived");
  end

  localparam logic [BEAT_W:0] LAST_BEAT = (BEAT_W + 1)'(BEATS - 1);
  localparam logic [BEAT_W:0] LAT_BEAT  = (BEAT_W + 1)'(READ_LAT);
  localparam logic [1:0]      TAIL_LAST = 2'(READ_LAT);
  localparam bit              HAS_TAIL  = (READ_LAT != 0);

  seq_state_e         state_q;
  logic [BEAT_W:0]    beat_q;
  logic [1:0]         tail_q;
  logic               write_q;
  logic [BASE_W-1:0]  base_q;
  logic [1:0]         sel_q;
  instr_t             word_q;
  logic               done_q;
  logic               active;

  // Read beats below READ_LAT only present the address; their data appears
  // on later beats or in the tail, giving exactly BEATS enabled cycles.
  function automatic instr_t beat_word(logic wr, logic [BASE_W-1:0] base,
                                       logic [1:0] sel, logic [BEAT_W:0] k);
    instr_t f;
    f                = '0;
    f.address        = {base, k[BEAT_W-1:0]};
    f.alu_opcode     = ALU_PASS;
    f.global_command = GCMD_NONE;
    f.ram_write      = wr;
    f.input_select   = wr ? sel : 2'b00;
    f.output_select  = !wr && (k >= LAT_BEAT);
    f.output_enable  = !wr && (k >= LAT_BEAT);
    return f;
  endfunction

  function automatic instr_t tail_word(logic [BASE_W-1:0] base);
    instr_t f;
    f                = '0;
    f.address        = {base, LAST_BEAT[BEAT_W-1:0]};
    f.alu_opcode     = ALU_PASS;
    f.global_command = GCMD_NONE;
    f.output_select  = 1'b1;
    f.output_enable  = 1'b1;
    return f;
  endfunction

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      beat_q  <= '0;
      tail_q  <= '0;
      write_q <= 1'b0;
      base_q  <= '0;
      sel_q   <= '0;
      word_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            write_q <= bus.write_i;
            base_q  <= bus.base_addr_i;
            sel_q   <= bus.input_select_i;
            beat_q  <= '0;
            word_q  <= beat_word(bus.write_i, bus.base_addr_i, bus.input_select_i, '0);
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (bus.abort_i) begin
            state_q <= IDLE;
            word_q  <= '0;
          end else if (beat_q == LAST_BEAT) begin
            if (write_q || !HAS_TAIL) begin
              state_q <= IDLE;
              word_q  <= '0;
            end else begin
              state_q <= TAIL;
              tail_q  <= 2'd1;
              word_q  <= tail_word(base_q);
              done_q  <= (TAIL_LAST == 2'd1);
            end
          end else begin
            beat_q <= beat_q + 1'b1;
            word_q <= beat_word(write_q, base_q, sel_q, beat_q + 1'b1);
            done_q <= ((beat_q + 1'b1) == LAST_BEAT) && (write_q || !HAS_TAIL);
          end
        end
        TAIL: begin
          if (bus.abort_i || (tail_q == TAIL_LAST)) begin
            state_q <= IDLE;
            word_q  <= '0;
          end else begin
            tail_q <= tail_q + 2'd1;
            word_q <= tail_word(base_q);
            done_q <= ((tail_q + 2'd1) == TAIL_LAST);
          end
        end
        default: begin
          state_q <= IDLE;
          word_q  <= '0;
        end
      endcase
    end
  end

  assign active            = (state_q != IDLE);
  assign bus.busy_o        = active;
  assign bus.instr_valid_o = active;
  assign bus.done_o        = done_q;

  instr_word_pack u_pack (
    .fields (word_q),
    .valid  (active),
    .word   (bus.instruction_o)
  );

endmodule

// File: tb/tb_burst_access_sequencer.sv
// Directed bench: default read/write bursts, an 8-beat zero-latency read,
// abort, held start and asynchronous reset in the read tail.
module tb_burst_access_sequencer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  logic [20:0] ew [16];

  burst_access_sequencer_if #(.BASE_W(6)) bus_a ();
  burst_access_sequencer_if #(.BASE_W(5)) bus_b ();

  burst_access_sequencer #(.BEATS(4), .READ_LAT(1)) dut_a (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_a.slave)
  );

  burst_access_sequencer #(.BEATS(8), .READ_LAT(0)) dut_b (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Independent word model: arithmetic on field offsets, ALU_PASS = 12.
  function automatic logic [20:0] exp_word(bit rw, int addr, int sel, bit oe);
    int w;
    w = (int'(rw) << 19) | (addr << 11) | (sel << 9) | (int'(oe) << 8)
      | (int'(oe) << 7) | (12 << 3);
    return w[20:0];
  endfunction

  task automatic fill_read_a(input int base);
    for (int k = 0; k < 4; k++) ew[k] = exp_word(1'b0, base * 4 + k, 0, k >= 1);
    ew[4] = exp_word(1'b0, base * 4 + 3, 0, 1'b1);
  endtask

  task automatic watch_a(input string tag, input int n, input bit drop_start);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s_valid%0d", tag, i), 32'(bus_a.instr_valid_o), 32'd1);
      check($sformatf("%s_busy%0d", tag, i), 32'(bus_a.busy_o), 32'd1);
      check($sformatf("%s_word%0d", tag, i), 32'(bus_a.instruction_o), 32'(ew[i]));
      check($sformatf("%s_done%0d", tag, i), 32'(bus_a.done_o), 32'(i == n - 1));
      if (drop_start) bus_a.start_i = 1'b0;
    end
  endtask

  task automatic watch_b(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s_valid%0d", tag, i), 32'(bus_b.instr_valid_o), 32'd1);
      check($sformatf("%s_word%0d", tag, i), 32'(bus_b.instruction_o), 32'(ew[i]));
      check($sformatf("%s_done%0d", tag, i), 32'(bus_b.done_o), 32'(i == n - 1));
    end
  endtask

  task automatic idle_a(input string tag);
    @(negedge clk);
    check({tag, "_valid"}, 32'(bus_a.instr_valid_o), 32'd0);
    check({tag, "_busy"}, 32'(bus_a.busy_o), 32'd0);
    check({tag, "_word"}, 32'(bus_a.instruction_o), 32'd0);
    check({tag, "_done"}, 32'(bus_a.done_o), 32'd0);
  endtask

  task automatic start_a(input bit wr, input logic [5:0] base, input logic [1:0] sel);
    bus_a.start_i        = 1'b1;
    bus_a.write_i        = wr;
    bus_a.base_addr_i    = base;
    bus_a.input_select_i = sel;
    @(posedge clk);
    #1 bus_a.start_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus_a.start_i = 1'b0; bus_a.write_i = 1'b0; bus_a.base_addr_i = '0;
    bus_a.input_select_i = '0; bus_a.abort_i = 1'b0;
    bus_b.start_i = 1'b0; bus_b.write_i = 1'b0; bus_b.base_addr_i = '0;
    bus_b.input_select_i = '0; bus_b.abort_i = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    @(negedge clk);
    check("rst_valid", 32'(bus_a.instr_valid_o), 32'd0);
    check("rst_busy", 32'(bus_a.busy_o), 32'd0);
    check("rst_done", 32'(bus_a.done_o), 32'd0);
    check("rst_word", 32'(bus_a.instruction_o), 32'd0);
    check("rst_word_b", 32'(bus_b.instruction_o), 32'd0);
    rst_n = 1'b1;

    // Read, base 5: input_select must be ignored in read mode.
    ew[0] = 21'h0A060; ew[1] = 21'h0A9E0; ew[2] = 21'h0B1E0;
    ew[3] = 21'h0B9E0; ew[4] = 21'h0B9E0;
    start_a(1'b0, 6'h05, 2'b11);
    watch_a("rd", 5, 1'b0);
    idle_a("rd_end");

    // Write, base 3F, select 2: addresses FC..FF, no output enable.
    ew[0] = 21'hFE460; ew[1] = 21'hFEC60; ew[2] = 21'hFF460; ew[3] = 21'hFFC60;
    start_a(1'b1, 6'h3F, 2'b10);
    watch_a("wr", 4, 1'b0);
    idle_a("wr_end");

    // Eight-beat read with no latency: every beat enabled, no tail.
    for (int k = 0; k < 8; k++) ew[k] = exp_word(1'b0, 'hD0 + k, 0, 1'b1);
    bus_b.start_i = 1'b1; bus_b.base_addr_i = 5'h1A;
    @(posedge clk);
    #1 bus_b.start_i = 1'b0;
    watch_b("rd8", 8);
    @(negedge clk);
    check("rd8_end_valid", 32'(bus_b.instr_valid_o), 32'd0);
    check("rd8_end_word", 32'(bus_b.instruction_o), 32'd0);

    // Abort on the second word.
    start_a(1'b0, 6'h01, 2'b00);
    @(negedge clk);
    check("ab_w0", 32'(bus_a.instruction_o), 32'(exp_word(1'b0, 4, 0, 1'b0)));
    @(negedge clk);
    check("ab_w1", 32'(bus_a.instruction_o), 32'(exp_word(1'b0, 5, 0, 1'b1)));
    bus_a.abort_i = 1'b1;
    @(negedge clk);
    check("ab_valid", 32'(bus_a.instr_valid_o), 32'd0);
    check("ab_word", 32'(bus_a.instruction_o), 32'd0);
    check("ab_done", 32'(bus_a.done_o), 32'd0);
    // Abort still high in IDLE must not block the next request.
    fill_read_a(1);
    start_a(1'b0, 6'h01, 2'b00);
    bus_a.abort_i = 1'b0;
    watch_a("ab_next", 5, 1'b0);
    idle_a("ab_next_end");

    // Held start: mid-burst input changes are ignored, then the next burst
    // starts two cycles after done.
    for (int k = 0; k < 4; k++) ew[k] = exp_word(1'b1, 'h40 + k, 1, 1'b0);
    bus_a.start_i = 1'b1; bus_a.write_i = 1'b1;
    bus_a.base_addr_i = 6'h10; bus_a.input_select_i = 2'b01;
    @(posedge clk);
    #1;
    bus_a.base_addr_i = 6'h20; bus_a.write_i = 1'b0; bus_a.input_select_i = 2'b11;
    watch_a("hold1", 4, 1'b0);
    idle_a("hold_gap");
    fill_read_a('h20);
    watch_a("hold2", 5, 1'b1);
    idle_a("hold_end");

    // Asynchronous reset while in the read tail.
    start_a(1'b0, 6'h02, 2'b00);
    repeat (4) @(posedge clk);
    #1;
    check("tail_pre_valid", 32'(bus_a.instr_valid_o), 32'd1);
    check("tail_pre_done", 32'(bus_a.done_o), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus_a.instr_valid_o), 32'd0);
    check("arst_busy", 32'(bus_a.busy_o), 32'd0);
    check("arst_done", 32'(bus_a.done_o), 32'd0);
    check("arst_word", 32'(bus_a.instruction_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_a("arst_after");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
